// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the serial nibble add/subtract sequencer.
package addsub_seq_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width; a single-nibble build still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_seq_if.sv
// Request/response bundle between the controller and the serial add/sub sequencer.
interface addsub_serial_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    import addsub_seq_pkg::*;

    localparam int unsigned WIDTH = NIB_W * NIBBLES;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, overflow, zero
    );

endinterface

// File: rtl/addsub_nibble.sv
// Combinational 4-bit add/subtract slice; exposes carry into bit 3 for overflow detection.
module addsub_nibble
    import addsub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W-1:0] w_bx;
    logic [NIB_W:0]   w_sum;
    logic [NIB_W-1:0] w_low;

    assign w_bx  = b ^ {NIB_W{sub}};
    assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{NIB_W{1'b0}}, cin};
    // Sum of the three low bits only; its top bit is the carry into bit 3.
    assign w_low = {1'b0, a[NIB_W-2:0]} + {1'b0, w_bx[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};

    assign s    = w_sum[NIB_W-1:0];
    assign cout = w_sum[NIB_W];
    assign c3   = w_low[NIB_W-1];

endmodule

// File: rtl/addsub_serial_seq.sv
// Wide add/subtract sequenced one nibble per cycle, LS nibble first, through one shared slice.
// Optional macro ADDSUB_SEQ_SATURATE_EN clamps the final result on signed overflow.
module addsub_serial_seq
    import addsub_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_serial_seq_if.slave bus
);

    localparam int unsigned WIDTH = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [IDX_W-1:0] r_idx;
    logic             r_cin;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_s;
    logic             w_cout;
    logic             w_c3;
    logic             w_ovf;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] w_final;

    assign w_a_nib = r_a[NIB_W*r_idx +: NIB_W];
    assign w_b_nib = r_b[NIB_W*r_idx +: NIB_W];
    assign w_ovf   = w_cout ^ w_c3;
    assign w_last  = (r_idx == LAST);

    addsub_nibble u_nib (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .sub  (r_op),
        .cin  (r_cin),
        .s    (w_s),
        .cout (w_cout),
        .c3   (w_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_result;
        w_res_nxt[NIB_W*r_idx +: NIB_W] = w_s;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ADDSUB_SEQ_SATURATE_EN
    // On overflow both MS operand signs agree, so A's sign picks the clamp direction.
    always_comb begin
        w_final = w_res_nxt;
        if (w_ovf) begin
            w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_final = w_res_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_idx      <= '0;
            r_cin      <= 1'b0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_op  <= bus.op;
                        r_idx <= '0;
                        r_cin <= bus.op;
                    end
                end
                RUN: begin
                    r_cin <= w_cout;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_result   <= w_final;
                        r_carry    <= w_cout;
                        r_overflow <= w_ovf;
                        r_zero     <= (w_final == '0);
                    end else begin
                        r_result   <= w_res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule
